uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter sharing the UART transmit path between `NUM_REQ` byte-stream requesters. It sits on the system clock in front of the UART transmit interface (`Tx_valid`, `Tx_err`, `input_tx`, `ready`). It grants one requester at a time for a whole burst, optionally prefixed with a header byte carrying the requester ID. Bursts end on `req_last` or are force-closed after `MAX_BURST` payload bytes.

## Interface

Parameters:
- `WIDTH_SIZE`, 8: byte width; must equal the UART `WIDTH_SIZE`.
- `NUM_REQ`, 4: number of requesters, 2..8.
- `HEADER_EN`, 1: 1 sends a header byte before each burst; 0 sends payload only.
- `MAX_BURST`, 16: maximum payload bytes per grant, 1..255.

Ports:
- `clk`, in, 1: system clock, same clock as UART `clk`.
- `reset`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, NUM_REQ: per-requester data valid.
- `req_data`, in, NUM_REQ*WIDTH_SIZE: requester i's byte is at `[i*WIDTH_SIZE +: WIDTH_SIZE]`.
- `req_last`, in, NUM_REQ: marks the final byte of a burst.
- `req_err`, in, NUM_REQ: per-byte parity-error injection request.
- `req_ready`, out, NUM_REQ: per-requester accept.
- `tx_valid`, out, 1: drives UART `Tx_valid`.
- `tx_data`, out, WIDTH_SIZE: drives UART `input_tx`.
- `tx_err`, out, 1: drives UART `Tx_err`.
- `tx_ready`, in, 1: from UART `ready`; already synchronous to `clk`.
- `grant_id`, out, clog2(NUM_REQ): index of the current or last granted requester.
- `busy`, out, 1: high in any state other than IDLE.
- `trunc`, out, 1: one-cycle pulse when a burst is force-closed at `MAX_BURST`.

## Operation

- FSM states: IDLE, HEADER, PAYLOAD.
- **Reset** (asynchronous, while `reset`=0):
  - state IDLE, round-robin pointer `rr`=0, `grant_id`=0, burst counter 0.
  - Outputs: `busy`=0, `trunc`=0, `tx_valid`=0, `tx_err`=0, `tx_data`=0, `req_ready`=0.
- **IDLE:**
  - If any `req_valid` is high, pick the first set bit searching upward from `rr` with wrap-around (`rr`, `rr+1`, … `NUM_REQ-1`, 0, …).
  - Register the winner in `grant_id` and clear the counter.
  - Next state is HEADER if `HEADER_EN`=1, else PAYLOAD.
  - Outputs `tx_valid`=0 and `req_ready`=0.
- **HEADER:**
  - `tx_valid`=1, `tx_err`=0.
  - `tx_data` = MSB set, `grant_id` in the low bits, zeros elsewhere (8-bit, id 2 gives 8'h82).
  - All `req_ready`=0.
  - On `tx_ready` go to PAYLOAD.
- **PAYLOAD** (combinational pass-through of the granted lane):
  - `tx_valid` = `req_valid[g]`, `tx_data` = `req_data[g]`, `tx_err` = `req_err[g]`.
  - `req_ready[g]` = `tx_ready`; all other lanes get `req_ready`=0.
  - A handshake (`req_valid[g]` and `tx_ready`) increments the counter.
  - The burst ends on a handshake with `req_last[g]`=1, or on the handshake that makes the counter reach `MAX_BURST`.
  - On burst end: go to IDLE and set `rr` = `g+1` mod `NUM_REQ`.
  - `trunc` pulses only when the end is caused by the counter without `req_last`.
- **Counter:** width is clog2(MAX_BURST+1) and it never wraps. A `req_last` on the `MAX_BURST`-th byte is a normal end with no `trunc`.
- **Stall:** if the granted requester drops `req_valid` mid-burst, the grant is held indefinitely. There is no timeout and no preemption.
- **Requester rule:** requesters hold `req_data`, `req_last` and `req_err` stable while `req_valid`=1 and `req_ready`=0. The arbiter does not check this.
- **Non-granted lanes:** a lane that asserts `req_valid` during another lane's burst waits. It is considered only in the next IDLE.
- **Reset mid-burst:** the burst is aborted immediately and the partial burst is not resumed.

## Timing

- Arbitration latency: `req_valid` rising in IDLE at edge N gives state HEADER (or PAYLOAD) after edge N+1, so the header `tx_valid` is visible in cycle N+1.
- The header byte is held with `tx_valid`=1 until `tx_ready`; it never drops without a handshake.
- Minimum gap between bursts: 1 IDLE cycle.
- Back-to-back bursts cost 2 + L cycles with header, or 1 + L without, assuming `tx_ready` is constant 1 and the burst has L bytes.
- `grant_id` is stable from the IDLE exit until the next grant.
- `busy` and `trunc` are registered.

## Test plan

- **Single requester, header on:** `NUM_REQ`=4, lane 2 sends 3 bytes 11,22,33 with `last` on 33 and `tx_ready`=1 → `tx_data` sequence 82,11,22,33 on consecutive cycles, then `busy`=0 and `rr`=3.
- **Round-robin fairness:** all 4 lanes hold 1-byte bursts continuously → grant order 0,1,2,3,0,1; no lane is granted twice before the others.
- **Truncation:** `MAX_BURST`=4, lane 1 streams 6 bytes with no `last` → 4 bytes forwarded, `trunc` pulses once, the next grant goes to another valid lane, and lane 1's remaining bytes form a new burst.
- **Back-pressure:** `tx_ready` toggles 1,0,0,1 during HEADER and PAYLOAD → `tx_valid` and `tx_data` are held stable while `tx_ready`=0, and no byte is duplicated or lost.
- **Mid-burst stall and error pass-through:**
  - Granted lane drops `req_valid` for 5 cycles → `tx_valid`=0 and the grant is held.
  - A byte with `req_err`=1 → `tx_err`=1 in that cycle only.
- **Reset and header-off:**
  - Assert `reset`=0 mid-burst → all outputs 0 asynchronously and state IDLE; after release, lane 0 is the first candidate.
  - With `HEADER_EN`=0, only payload bytes appear.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmit path between several
// byte-stream requesters, granting a whole burst at a time with an optional ID header.
module uart_tx_arbiter #(
    parameter int WIDTH_SIZE = 8,
    parameter int NUM_REQ    = 4,
    parameter int HEADER_EN  = 1,
    parameter int MAX_BURST  = 16,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*WIDTH_SIZE-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ-1:0]            req_err,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [WIDTH_SIZE-1:0]         tx_data,
    output logic                          tx_err,
    input  logic                          tx_ready,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy,
    output logic                          trunc
);

    typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAYLOAD} state_t;

    localparam logic [GW:0] NUM_W = (GW + 1)'(NUM_REQ);

    state_t          state_reg, state_next;
    logic [GW-1:0]   rr_reg, rr_next;
    logic [GW-1:0]   grant_reg, grant_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            busy_reg;
    logic            trunc_reg, trunc_next;

    logic [WIDTH_SIZE-1:0] lane_data [NUM_REQ];
    logic [NUM_REQ-1:0]    rot;
    logic [NUM_REQ:0]      found;
    logic [GW-1:0]         off_chain [NUM_REQ+1];
    logic [GW:0]           pick_sum;
    logic [GW-1:0]         pick;
    logic                  any_req;
    logic [WIDTH_SIZE-1:0] hdr_byte;
    logic                  hs;
    logic                  at_max;

    // Requests rotated so that bit 0 is the lane the pointer currently favours.
    assign rot = NUM_REQ'({req_valid, req_valid} >> rr_reg);

    assign found[0]     = 1'b0;
    assign off_chain[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane_data[gi]    = req_data[gi*WIDTH_SIZE +: WIDTH_SIZE];
            assign found[gi+1]      = found[gi] | rot[gi];
            assign off_chain[gi+1]  = (rot[gi] && !found[gi]) ? GW'(gi) : off_chain[gi];
        end
    endgenerate

    assign any_req  = found[NUM_REQ];
    assign pick_sum = {1'b0, rr_reg} + {1'b0, off_chain[NUM_REQ]};
    assign pick     = GW'((pick_sum >= NUM_W) ? (pick_sum - NUM_W) : pick_sum);

    assign hdr_byte = {1'b1, {(WIDTH_SIZE-1-GW){1'b0}}, grant_reg};
    assign hs       = req_valid[grant_reg] & tx_ready;
    assign at_max   = (cnt_reg == CW'(MAX_BURST - 1));

    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        grant_next = grant_reg;
        cnt_next   = cnt_reg;
        trunc_next = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        tx_err     = 1'b0;
        req_ready  = '0;
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    grant_next = pick;
                    cnt_next   = '0;
                    state_next = (HEADER_EN != 0) ? ST_HEADER : ST_PAYLOAD;
                end
            end
            ST_HEADER: begin
                tx_valid = 1'b1;
                tx_data  = hdr_byte;
                if (tx_ready) begin
                    state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                tx_valid             = req_valid[grant_reg];
                tx_data              = lane_data[grant_reg];
                tx_err               = req_err[grant_reg];
                req_ready[grant_reg] = tx_ready;
                if (hs) begin
                    cnt_next = cnt_reg + 1'b1;
                    // A last flag on the final allowed byte is a clean end, not a truncation.
                    if (req_last[grant_reg] || at_max) begin
                        state_next = ST_IDLE;
                        rr_next    = (grant_reg == GW'(NUM_REQ - 1)) ? '0 : grant_reg + 1'b1;
                        trunc_next = ~req_last[grant_reg];
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            rr_reg    <= '0;
            grant_reg <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            trunc_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
            grant_reg <= grant_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= (state_next != ST_IDLE);
            trunc_reg <= trunc_next;
        end
    end

    assign grant_id = grant_reg;
    assign busy     = busy_reg;
    assign trunc    = trunc_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: header/payload sequencing, fairness,
// truncation, back-pressure, stall, error pass-through, reset and header-off.
module tb_uart_tx_arbiter;
    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_err = '0;
    logic [N*W-1:0] req_data = '0;
    logic           tx_ready = 1'b0;

    logic [N-1:0]   req_ready, req_ready2;
    logic           tx_valid, tx_err, busy, trunc;
    logic           tx_valid2, tx_err2, busy2, trunc2;
    logic [W-1:0]   tx_data, tx_data2;
    logic [1:0]     grant_id, grant_id2;

    int passed = 0;
    int total  = 0;
    int ord [6] = '{3, 0, 1, 2, 3, 0};

    uart_tx_arbiter #(.WIDTH_SIZE(W), .NUM_REQ(N), .HEADER_EN(1), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_err(req_err), .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_err(tx_err), .tx_ready(tx_ready),
        .grant_id(grant_id), .busy(busy), .trunc(trunc)
    );

    uart_tx_arbiter #(.WIDTH_SIZE(W), .NUM_REQ(N), .HEADER_EN(0), .MAX_BURST(16)) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_err(req_err), .req_ready(req_ready2),
        .tx_valid(tx_valid2), .tx_data(tx_data2), .tx_err(tx_err2), .tx_ready(tx_ready),
        .grant_id(grant_id2), .busy(busy2), .trunc(trunc2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic lane(input int i, input logic v, input logic [7:0] d, input logic l, input logic e);
        req_valid[i]       = v;
        req_data[i*W +: W] = d;
        req_last[i]        = l;
        req_err[i]         = e;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        settle();
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_trunc", 32'(trunc), 32'h0);
        check("rst_txv",   32'(tx_valid), 32'h0);
        check("rst_txd",   32'(tx_data), 32'h0);
        check("rst_txerr", 32'(tx_err), 32'h0);
        check("rst_rdy",   32'(req_ready), 32'h0);
        check("rst_gid",   32'(grant_id), 32'h0);
        tick();
        reset = 1'b1;

        // Single requester, lane 2: 82,11,22,33
        lane(2, 1'b1, 8'h11, 1'b0, 1'b0);
        tx_ready = 1'b1;
        settle();
        check("s_idle_txv", 32'(tx_valid), 32'h0);
        check("s_idle_rdy", 32'(req_ready), 32'h0);
        tick();
        settle();
        check("s_hdr_txd",  32'(tx_data), 32'h82);
        check("s_hdr_txv",  32'(tx_valid), 32'h1);
        check("s_hdr_rdy",  32'(req_ready), 32'h0);
        check("s_hdr_busy", 32'(busy), 32'h1);
        check("s_hdr_gid",  32'(grant_id), 32'h2);
        tick();
        settle();
        check("s_b0_txd", 32'(tx_data), 32'h11);
        check("s_b0_rdy", 32'(req_ready), 32'h4);
        tick();
        lane(2, 1'b1, 8'h22, 1'b0, 1'b0);
        settle();
        check("s_b1_txd", 32'(tx_data), 32'h22);
        tick();
        lane(2, 1'b1, 8'h33, 1'b1, 1'b0);
        settle();
        check("s_b2_txd", 32'(tx_data), 32'h33);
        tick();
        lane(2, 1'b0, 8'h00, 1'b0, 1'b0);
        settle();
        check("s_end_busy", 32'(busy), 32'h0);
        check("s_end_txv",  32'(tx_valid), 32'h0);
        tick();

        // Fairness: every lane holds 1-byte bursts; pointer starts at 3
        for (int i = 0; i < N; i++) lane(i, 1'b1, 8'(8'hA0 + i), 1'b1, 1'b0);
        for (int j = 0; j < 6; j++) begin
            tick();
            settle();
            check("rr_gid", 32'(grant_id), 32'(ord[j]));
            check("rr_hdr", 32'(tx_data), 32'(8'h80 | ord[j]));
            tick();
            settle();
            check("rr_txd", 32'(tx_data), 32'(8'hA0 + ord[j]));
            check("rr_rdy", 32'(req_ready), 32'(1 << ord[j]));
            tick();
            settle();
            check("rr_gap_busy", 32'(busy), 32'h0);
        end
        req_valid = '0;
        req_last  = '0;
        tick();

        // Truncation: lane 1 streams without last, lane 3 waits
        lane(1, 1'b1, 8'h51, 1'b0, 1'b0);
        lane(3, 1'b1, 8'h3C, 1'b1, 1'b0);
        tick();
        settle();
        check("tr_gid", 32'(grant_id), 32'h1);
        check("tr_hdr", 32'(tx_data), 32'h81);
        tick();
        for (int b = 0; b < 4; b++) begin
            settle();
            check("tr_txd",   32'(tx_data), 32'(8'h51 + b));
            check("tr_trunc0", 32'(trunc), 32'h0);
            tick();
            lane(1, 1'b1, 8'(8'h52 + b), 1'b0, 1'b0);
        end
        settle();
        check("tr_pulse", 32'(trunc), 32'h1);
        check("tr_busy",  32'(busy), 32'h0);
        tick();
        settle();
        check("tr_next_gid", 32'(grant_id), 32'h3);
        check("tr_next_hdr", 32'(tx_data), 32'h83);
        check("tr_once",     32'(trunc), 32'h0);
        tick();
        settle();
        check("tr_l3_txd", 32'(tx_data), 32'h3C);
        tick();
        lane(3, 1'b0, 8'h00, 1'b0, 1'b0);
        settle();
        check("tr_l3_trunc", 32'(trunc), 32'h0);
        tick();
        settle();
        check("tr_rest_gid", 32'(grant_id), 32'h1);
        tick();
        settle();
        check("tr_rest_b0", 32'(tx_data), 32'h55);
        tick();
        lane(1, 1'b1, 8'h56, 1'b1, 1'b0);
        settle();
        check("tr_rest_b1", 32'(tx_data), 32'h56);
        tick();
        lane(1, 1'b0, 8'h00, 1'b0, 1'b0);
        settle();
        check("tr_rest_trunc", 32'(trunc), 32'h0);
        check("tr_rest_busy",  32'(busy), 32'h0);

        // Back-pressure on lane 2 during header and payload
        lane(2, 1'b1, 8'hC1, 1'b0, 1'b0);
        tx_ready = 1'b0;
        tick();
        settle();
        check("bp_h0_txd", 32'(tx_data), 32'h82);
        check("bp_h0_txv", 32'(tx_valid), 32'h1);
        tick();
        settle();
        check("bp_h1_txd", 32'(tx_data), 32'h82);
        check("bp_h1_txv", 32'(tx_valid), 32'h1);
        tick();
        tx_ready = 1'b1;
        settle();
        check("bp_h2_txd", 32'(tx_data), 32'h82);
        tick();
        tx_ready = 1'b0;
        settle();
        check("bp_p0_txd", 32'(tx_data), 32'hC1);
        check("bp_p0_rdy", 32'(req_ready), 32'h0);
        tick();
        settle();
        check("bp_p1_txd", 32'(tx_data), 32'hC1);
        check("bp_p1_txv", 32'(tx_valid), 32'h1);
        tick();
        tx_ready = 1'b1;
        settle();
        check("bp_p2_txd", 32'(tx_data), 32'hC1);
        check("bp_p2_rdy", 32'(req_ready), 32'h4);
        tick();
        lane(2, 1'b1, 8'hC2, 1'b1, 1'b0);
        settle();
        check("bp_p3_txd", 32'(tx_data), 32'hC2);
        tick();
        lane(2, 1'b0, 8'h00, 1'b0, 1'b0);
        settle();
        check("bp_end_busy", 32'(busy), 32'h0);

        // Mid-burst stall and error pass-through on lane 0
        lane(0, 1'b1, 8'hD1, 1'b0, 1'b0);
        tick();
        settle();
        check("st_hdr", 32'(tx_data), 32'h80);
        tick();
        settle();
        check("st_b0_txd", 32'(tx_data), 32'hD1);
        check("st_b0_err", 32'(tx_err), 32'h0);
        tick();
        lane(0, 1'b0, 8'hD2, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            settle();
            check("st_txv",  32'(tx_valid), 32'h0);
            check("st_busy", 32'(busy), 32'h1);
            check("st_gid",  32'(grant_id), 32'h0);
            tick();
        end
        lane(0, 1'b1, 8'hD2, 1'b0, 1'b1);
        settle();
        check("er_txd", 32'(tx_data), 32'hD2);
        check("er_err", 32'(tx_err), 32'h1);
        tick();
        lane(0, 1'b1, 8'hD3, 1'b1, 1'b0);
        settle();
        check("er_txd2", 32'(tx_data), 32'hD3);
        check("er_err2", 32'(tx_err), 32'h0);
        tick();
        lane(0, 1'b0, 8'h00, 1'b0, 1'b0);
        settle();
        check("er_busy", 32'(busy), 32'h0);

        // Asynchronous reset in the middle of a lane 1 burst
        lane(1, 1'b1, 8'hE1, 1'b0, 1'b0);
        tick();
        tick();
        settle();
        check("ar_pre_busy", 32'(busy), 32'h1);
        check("ar_pre_txd",  32'(tx_data), 32'hE1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_txv",   32'(tx_valid), 32'h0);
        check("ar_txd",   32'(tx_data), 32'h0);
        check("ar_rdy",   32'(req_ready), 32'h0);
        check("ar_busy",  32'(busy), 32'h0);
        check("ar_gid",   32'(grant_id), 32'h0);
        check("ar_txv2",  32'(tx_valid2), 32'h0);
        lane(0, 1'b1, 8'hF1, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        settle();
        check("ar_idle_txv", 32'(tx_valid), 32'h0);

        // Lane 0 wins after reset; header-off instance shows payload only
        tick();
        settle();
        check("ar_first_gid", 32'(grant_id), 32'h0);
        check("ar_first_hdr", 32'(tx_data), 32'h80);
        check("ho_gid",  32'(grant_id2), 32'h0);
        check("ho_b0",   32'(tx_data2), 32'hF1);
        check("ho_txv",  32'(tx_valid2), 32'h1);
        tick();
        lane(0, 1'b1, 8'hF2, 1'b1, 1'b0);
        settle();
        check("ho_b1",   32'(tx_data2), 32'hF2);
        tick();
        req_valid = '0;
        req_last  = '0;
        settle();
        check("ho_busy", 32'(busy2), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
